led_blink_multi: RTL and testbench

Parametrised multi-channel LED pattern generator, the successor of the single fixed-rate heartbeat blinker in the board top level. It derives a millisecond-class tick from the system clock and drives NCH LED outputs, each independently configurable at run time as OFF, ON, BLINK or BURST with a programmable half-period. It sits in the top level beside the reset generator, fed by the system clock and a small config port (switches or a register bank).

---
 rtl/led_blink_pkg.sv | 21 ++
 rtl/led_blink_chan.sv | 121 ++++++++++++
 rtl/led_blink_multi.sv | 91 +++++++++
 tb/tb_led_blink_multi.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/led_blink_pkg.sv
// Shared types and constants for the multi-channel LED pattern generator.
// Imported by led_blink_chan and led_blink_multi.
package led_blink_pkg;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'b00,
      MODE_ON    = 2'b01,
      MODE_BLINK = 2'b10,
      MODE_BURST = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      S_ON    = 2'd0,
      S_OFF   = 2'd1,
      S_PAUSE = 2'd2
   } phase_e;

   localparam int PWM_W      = 4;
   localparam int PAUSE_MULT = 4;

endpackage

// File: rtl/led_blink_chan.sv
// One LED channel: mode/half-period registers and the BLINK/BURST phase FSM.
// phase_on is combinational from the channel registers; the top registers it onto led.
module led_blink_chan
   import led_blink_pkg::*;
#(
   parameter int HALF_W       = 10,
   parameter int DEFAULT_HALF = 500,
   parameter int BURST_N      = 3
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              tick,
   input  logic              load,
   input  mode_e             mode,
   input  logic [HALF_W-1:0] half,
   output logic              phase_on
);

   localparam int CNT_W = HALF_W + 2;
   localparam int FL_W  = (BURST_N > 1) ? $clog2(BURST_N) : 1;

   mode_e              mode_q,  mode_d;
   logic [HALF_W-1:0]  half_q,  half_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;
   logic [FL_W-1:0]    flash_q, flash_d;
   phase_e             phase_q, phase_d;

   logic [CNT_W-1:0]   half_last;
   logic [CNT_W-1:0]   pause_last;

   // A programmed half-period of 0 behaves as 1 tick.
   always_comb begin
      half_last  = (half_q == '0) ? '0 : CNT_W'(half_q) - CNT_W'(1);
      pause_last = CNT_W'(PAUSE_MULT) * (half_last + CNT_W'(1)) - CNT_W'(1);
   end

   // NOTE: state registers update with non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         mode_q  <= MODE_OFF;
         half_q  <= HALF_W'(DEFAULT_HALF);
         cnt_q   <= '0;
         flash_q <= '0;
         phase_q <= S_ON;
      end else begin
         mode_q  <= mode_d;
         half_q  <= half_d;
         cnt_q   <= cnt_d;
         flash_q <= flash_d;
         phase_q <= phase_d;
      end
   end

   // NOTE: every signal driven here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      mode_d   = mode_q;
      half_d   = half_q;
      cnt_d    = cnt_q;
      flash_d  = flash_q;
      phase_d  = phase_q;
      phase_on = 1'b0;

      case (mode_q)
         MODE_OFF: phase_on = 1'b0;
         MODE_ON:  phase_on = 1'b1;
         default:  phase_on = (phase_q == S_ON);
      endcase

      // A write to this channel overrides a coincident tick.
      if (load) begin
         mode_d  = mode;
         half_d  = half;
         cnt_d   = '0;
         flash_d = '0;
         phase_d = S_ON;
      end else if (tick) begin
         cnt_d = cnt_q + CNT_W'(1);
         case (mode_q)
            MODE_BLINK: begin
               if (cnt_q == half_last) begin
                  cnt_d   = '0;
                  phase_d = (phase_q == S_ON) ? S_OFF : S_ON;
               end
            end
            MODE_BURST: begin
               case (phase_q)
                  S_ON: begin
                     if (cnt_q == half_last) begin
                        cnt_d   = '0;
                        phase_d = S_OFF;
                     end
                  end
                  S_OFF: begin
                     if (cnt_q == half_last) begin
                        cnt_d = '0;
                        if (flash_q == FL_W'(BURST_N - 1)) begin
                           flash_d = '0;
                           phase_d = S_PAUSE;
                        end else begin
                           flash_d = flash_q + FL_W'(1);
                           phase_d = S_ON;
                        end
                     end
                  end
                  default: begin
                     if (cnt_q == pause_last) begin
                        cnt_d   = '0;
                        flash_d = '0;
                        phase_d = S_ON;
                     end
                  end
               endcase
            end
            default: cnt_d = cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/led_blink_multi.sv
// Multi-channel LED pattern generator: tick prescaler, config write decode and NCH channels.
// Optional LED_BLINK_PWM_EN adds cfg_duty and a shared 4-bit PWM brightness gate.
module led_blink_multi
   import led_blink_pkg::*;
#(
   parameter int  CLK_FREQ     = 50_000_000,
   parameter int  TICK_HZ      = 1000,
   parameter int  NCH          = 4,
   parameter int  HALF_W       = 10,
   parameter int  DEFAULT_HALF = 500,
   parameter int  BURST_N      = 3,
   localparam int CH_W         = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              cfg_we,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [1:0]        cfg_mode,
   input  logic [HALF_W-1:0] cfg_half,
`ifdef LED_BLINK_PWM_EN
   input  logic [PWM_W-1:0]  cfg_duty,
`endif
   output logic [NCH-1:0]    led,
   output logic              tick_o
);

   localparam int DIV = CLK_FREQ / TICK_HZ;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

   logic [PW-1:0]  presc;
   logic           tick;
   logic [NCH-1:0] phase_on;
   logic [NCH-1:0] led_d;

   assign tick   = (presc == PW'(DIV - 1));
   assign tick_o = tick;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)     presc <= '0;
      else if (tick) presc <= '0;
      else           presc <= presc + PW'(1);
   end

`ifdef LED_BLINK_PWM_EN
   logic [PWM_W-1:0] pwm_cnt;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) pwm_cnt <= '0;
      else       pwm_cnt <= pwm_cnt + PWM_W'(1);
   end
`endif

   // Writes addressed beyond NCH match no channel and are dropped.
   for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic load;
      assign load = cfg_we && (cfg_ch == CH_W'(i));

      led_blink_chan #(
         .HALF_W       (HALF_W),
         .DEFAULT_HALF (DEFAULT_HALF),
         .BURST_N      (BURST_N)
      ) u_chan (
         .clk      (clk),
         .nrst     (nrst),
         .tick     (tick),
         .load     (load),
         .mode     (mode_e'(cfg_mode)),
         .half     (cfg_half),
         .phase_on (phase_on[i])
      );

`ifdef LED_BLINK_PWM_EN
      logic [PWM_W-1:0] duty;

      always_ff @(posedge clk or negedge nrst) begin
         if (!nrst)     duty <= '1;
         else if (load) duty <= cfg_duty;
      end

      assign led_d[i] = phase_on[i] & (pwm_cnt <= duty);
`else
      assign led_d[i] = phase_on[i];
`endif
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) led <= '0;
      else       led <= led_d;
   end

endmodule

// File: tb/tb_led_blink_multi.sv
// Self-checking bench for led_blink_multi: directed scenarios plus random config writes,
// compared every cycle against a tick-count reference model (honours LED_BLINK_PWM_EN).
module tb_led_blink_multi;

   localparam int CLK_FREQ = 1000;
   localparam int TICK_HZ  = 100;
   localparam int DIV      = CLK_FREQ / TICK_HZ;
   localparam int NCH      = 3;
   localparam int HALF_W   = 10;
   localparam int DEF_HALF = 500;
   localparam int BURST_N  = 2;

   logic              clk      = 1'b0;
   logic              nrst     = 1'b0;
   logic              cfg_we   = 1'b0;
   logic [1:0]        cfg_ch   = '0;
   logic [1:0]        cfg_mode = '0;
   logic [HALF_W-1:0] cfg_half = '0;
`ifdef LED_BLINK_PWM_EN
   logic [3:0]        cfg_duty = 4'hF;
`endif
   logic [NCH-1:0]    led;
   logic              tick_o;

   int n_checks = 0;
   int n_fail   = 0;
   int edge_n   = 0;
   int m_mode [NCH];
   int m_half [NCH];
   int m_t    [NCH];
   int m_duty [NCH];

   always #10 clk = ~clk;

   led_blink_multi #(
      .CLK_FREQ     (CLK_FREQ),
      .TICK_HZ      (TICK_HZ),
      .NCH          (NCH),
      .HALF_W       (HALF_W),
      .DEFAULT_HALF (DEF_HALF),
      .BURST_N      (BURST_N)
   ) dut (
      .clk      (clk),
      .nrst     (nrst),
      .cfg_we   (cfg_we),
      .cfg_ch   (cfg_ch),
      .cfg_mode (cfg_mode),
      .cfg_half (cfg_half),
`ifdef LED_BLINK_PWM_EN
      .cfg_duty (cfg_duty),
`endif
      .led      (led),
      .tick_o   (tick_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (edge %0d)", tag, got, exp, edge_n);
      end
   endtask

   // LED level as a function of ticks consumed since the channel's last write.
   function automatic bit model_on(input int ch);
      int h, r, per;
      h = (m_half[ch] == 0) ? 1 : m_half[ch];
      case (m_mode[ch])
         0: return 1'b0;
         1: return 1'b1;
         2: return ((m_t[ch] / h) % 2) == 0;
         default: begin
            per = (2 * BURST_N + 4) * h;
            r   = m_t[ch] % per;
            return (r < 2 * BURST_N * h) && (((r / h) % 2) == 0);
         end
      endcase
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_mode[c] = 0;
         m_half[c] = DEF_HALF;
         m_t[c]    = 0;
         m_duty[c] = 15;
      end
      edge_n = 0;
   endtask

   // One clock: predict led from pre-edge model state, advance the model, compare.
   task automatic cycle();
      logic [NCH-1:0] exp_led;
      bit             tick_now;
      for (int c = 0; c < NCH; c++) begin
         exp_led[c] = model_on(c);
`ifdef LED_BLINK_PWM_EN
         if ((edge_n % 16) > m_duty[c]) exp_led[c] = 1'b0;
`endif
      end
      tick_now = ((edge_n + 1) % DIV) == 0;
      @(posedge clk);
      for (int c = 0; c < NCH; c++) begin
         if (cfg_we && int'(cfg_ch) == c) begin
            m_mode[c] = int'(cfg_mode);
            m_half[c] = int'(cfg_half);
            m_t[c]    = 0;
`ifdef LED_BLINK_PWM_EN
            m_duty[c] = int'(cfg_duty);
`endif
         end else if (tick_now) begin
            m_t[c]++;
         end
      end
      edge_n++;
      #1;
      check("led", led, exp_led);
      check("tick_o", tick_o, ((edge_n + 1) % DIV) == 0);
   endtask

   task automatic write(input int ch, input int mode, input int half, input int duty);
      cfg_we   = 1'b1;
      cfg_ch   = 2'(ch);
      cfg_mode = 2'(mode);
      cfg_half = HALF_W'(half);
`ifdef LED_BLINK_PWM_EN
      cfg_duty = 4'(duty);
`else
      if (duty < 0) cfg_mode = 2'(mode);
`endif
      cycle();
      cfg_we = 1'b0;
   endtask

   initial begin
      int highs;

      model_reset();
      nrst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_led", led, '0);
      check("rst_tick", tick_o, 1'b0);
      nrst = 1'b1;
      repeat (25) cycle();

      write(1, 1, 5, 15);
      cycle();
      check("ch1_on", led, 3'b010);

      // Write BLINK in the same cycle as a tick: the tick must not advance ch0.
      while (((edge_n + 1) % DIV) != 0) cycle();
      write(0, 2, 3, 15);
      highs = 0;
      repeat (60) begin
         cycle();
         highs += int'(led[0]);
      end
      check("blink_high_cycles", highs, 30);

      write(2, 3, 1, 15);
      repeat (200) cycle();

      write(3, 2, 2, 0);
      repeat (50) cycle();

      // Asynchronous reset between edges while ch1 is lit.
      check("pre_rst_led1", led[1], 1'b1);
      nrst = 1'b0;
      #2;
      check("async_rst_led", led, '0);
      check("async_rst_tick", tick_o, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("hold_rst_led", led, '0);
      nrst = 1'b1;
      model_reset();

      repeat (3000) begin
         if ($urandom_range(0, 29) == 0)
            write(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 4)), int'($urandom_range(0, 15)));
         else
            cycle();
      end

`ifdef LED_BLINK_PWM_EN
      write(0, 1, 1, 3);
      cycle();
      highs = 0;
      repeat (16) begin
         cycle();
         highs += int'(led[0]);
      end
      check("pwm_duty3", highs, 4);
      write(0, 1, 1, 15);
      cycle();
      highs = 0;
      repeat (16) begin
         cycle();
         highs += int'(led[0]);
      end
      check("pwm_duty15", highs, 16);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
